ts_multichan_capture: RTL

Parametrised N-channel timestamp capture core, the successor to the fixed four-channel capture path inside `system`. Each channel synchronises its input, detects the configured edge type and latches a free-running timestamp. Pending events are arbitrated round-robin and emitted as byte packets over a valid/ready stream for the serial transmitter. Per-channel overflow is flagged when events are lost under backpressure.

---
 rtl/ts_multichan_capture_pkg.sv | 25 ++
 rtl/ts_multichan_capture_if.sv | 10 +
 rtl/ts_multichan_capture_chan.sv | 82 ++++++++
 rtl/ts_multichan_capture.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ts_multichan_capture_pkg.sv
// Shared types and constants for the multichannel timestamp capture core.
// Holds edge-mode encodings, header bit positions and the packet length helper.
package ts_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } ser_state_e;

    localparam int HDR_MARK   = 7;
    localparam int HDR_OVF    = 6;
    localparam int HDR_CH_MSB = 2;

    function automatic int pkt_len(input int ts_width);
        return 1 + ts_width / 8;
    endfunction

endpackage

// File: rtl/ts_multichan_capture_if.sv
// Byte stream towards the serial transmitter.
// master drives tx_data/tx_valid, slave returns tx_ready.
interface ts_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ts_multichan_capture_chan.sv
// One capture channel: synchroniser, edge qualifier, holding register, ovf.
// in: clk, rstn, datain, ts_now, en, edge_sel, grant  out: pending, ovf, ts_hold
module ts_chan_capture
    import ts_pkg::*;
#(
    parameter int TS_WIDTH    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                datain,
    input  logic [TS_WIDTH-1:0] ts_now,
    input  logic                en,
    input  logic [1:0]          edge_sel,
    input  logic                grant,
    output logic                pending,
    output logic                ovf,
    output logic [TS_WIDTH-1:0] ts_hold
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic [TS_WIDTH-1:0]    hold_q, hold_d;
    logic                   s_out, rise, fall, qual;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], datain};
        s_out  = sync_q[SYNC_STAGES-1];
        // prev tracks the input even while disabled, so re-enabling
        // never manufactures an edge
        prev_d = s_out;
        rise   = s_out & ~prev_q;
        fall   = ~s_out & prev_q;
        case (edge_mode_e'(edge_sel))
            EDGE_RISE: qual = rise;
            EDGE_FALL: qual = fall;
            EDGE_BOTH: qual = rise | fall;
            default:   qual = 1'b0;
        endcase
        qual   = qual & en;

        pend_d = pend_q;
        ovf_d  = ovf_q;
        hold_d = hold_q;
        if (grant) begin
            pend_d = 1'b0;
            ovf_d  = 1'b0;
        end
        // the slot freed by a grant in this cycle can take a new event
        if (qual) begin
            if (!pend_q || grant) begin
                pend_d = 1'b1;
                hold_d = ts_now;
            end else begin
                ovf_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            hold_q <= hold_d;
        end
    end

    assign pending = pend_q;
    assign ovf     = ovf_q;
    assign ts_hold = hold_q;

endmodule

// File: rtl/ts_multichan_capture.sv
// N-channel timestamp capture: counter, round-robin arbiter, byte serializer.
// in: clk, rstn, en, edge_sel, datain  out: tx (stream), ts_now, pending, busy
module ts_multichan_capture
    import ts_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TS_WIDTH    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [2*NUM_CH-1:0] edge_sel,
    input  logic [NUM_CH-1:0]   datain,
    ts_tx_if.master             tx,
    output logic [TS_WIDTH-1:0] ts_now,
    output logic [NUM_CH-1:0]   pending,
    output logic                busy
);

    localparam int PKT_LEN = pkt_len(TS_WIDTH);
    localparam int PKT_W   = PKT_LEN * 8;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W   = $clog2(PKT_LEN);

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [NUM_CH-1:0]   grant, ovf;
    logic [TS_WIDTH-1:0] ts_hold [NUM_CH];

    ser_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PKT_W-1:0]    sh_q, sh_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;

    logic                found;
    logic [CH_W-1:0]     sel;
    logic                xfer, last, can_grant;
    logic [7:0]          hdr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ts_chan_capture #(
            .TS_WIDTH    (TS_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .rstn     (rstn),
            .datain   (datain[i]),
            .ts_now   (ts_q),
            .en       (en),
            .edge_sel (edge_sel[2*i +: 2]),
            .grant    (grant[i]),
            .pending  (pending[i]),
            .ovf      (ovf[i]),
            .ts_hold  (ts_hold[i])
        );
    end

    // round-robin search beginning just after the last granted channel
    always_comb begin
        int          idx;
        logic [CH_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_W'(idx);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        ts_d      = ts_q + 1'b1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        grant     = '0;

        hdr                 = 8'h00;
        hdr[HDR_MARK]       = 1'b1;
        hdr[HDR_OVF]        = ovf[sel];
        hdr[HDR_CH_MSB:0]   = 3'(sel);

        xfer      = (state_q == S_SEND) && tx.tx_ready;
        last      = (cnt_q == CNT_W'(PKT_LEN - 1));
        // a new packet may start only while idle or as the last byte leaves
        can_grant = (state_q == S_IDLE) || (xfer && last);

        if (xfer) begin
            sh_d  = {sh_q[PKT_W-9:0], 8'h00};
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end
        if (can_grant && found) begin
            grant[sel] = 1'b1;
            ptr_d      = sel;
            sh_d       = {hdr, ts_hold[sel]};
            cnt_d      = '0;
            state_d    = S_SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ts_q    <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
        end else begin
            ts_q    <= ts_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
        end
    end

    assign tx.tx_data  = sh_q[PKT_W-1 -: 8];
    assign tx.tx_valid = (state_q == S_SEND);
    assign busy        = (state_q == S_SEND);
    assign ts_now      = ts_q;

endmodule
